pixel_pool_block: RTL

Downstream consumer of the camera pixel-stream stage. It takes the captured RGB565 pixel stream, converts each pixel to 8-bit greyscale, and box-averages non-overlapping POOL×POOL tiles. Each downsampled pixel is written, with its linear address, into the neural-net input memory. With the default parameters, a 224×224 window becomes a 28×28 input image, and `frame_ready` fires when the image is complete.

---
 rtl/pixel_pool_block.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/pixel_pool_block.sv
// RGB565 pixel stream -> 8-bit greyscale -> POOL x POOL box average.
// Each finished tile is emitted with its row-major address into the NN input memory.
module pixel_pool_block #(
  parameter int IMG_W  = 224,
  parameter int IMG_H  = 224,
  parameter int POOL   = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              frame_end,
  input  logic              pixel_valid,
  input  logic [15:0]       pixel_data,
  output logic              out_valid,
  output logic [7:0]        out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              frame_ready,
  output logic              frame_error,
  output logic              busy
);

  localparam int OUT_W = IMG_W / POOL;
  localparam int SH    = $clog2(POOL);
  localparam int ACC_W = 8 + 2 * SH;
  localparam int XW    = $clog2(IMG_W);
  localparam int YW    = $clog2(IMG_H + 1);
  localparam int CW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  localparam logic [YW-1:0] Y_END  = YW'(IMG_H);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_e;

  state_e state_q, state_d;
  logic [XW-1:0] x_q, x_d, x_base;
  logic [YW-1:0] y_q, y_d, y_base;
  logic          flush, accept, c_done, final_in;
  logic          frame_error_q, frame_error_d;
  logic          frame_ready_q, frame_ready_d;

  // Stage A: sampled pixel plus its tile bookkeeping
  logic              a_valid_q, a_valid_d;
  logic [15:0]       a_data_q, a_data_d;
  logic [CW-1:0]     a_col_q, a_col_d;
  logic              a_last_q, a_last_d;
  logic              a_flast_q, a_flast_d;
  logic [ADDR_W-1:0] a_addr_q, a_addr_d;

  // Stage B: greyscale value
  logic              b_valid_q, b_valid_d;
  logic [7:0]        b_gray_q, b_gray_d;
  logic [CW-1:0]     b_col_q, b_col_d;
  logic              b_last_q, b_last_d;
  logic              b_flast_q, b_flast_d;
  logic [ADDR_W-1:0] b_addr_q, b_addr_d;

  // Stage C: column accumulators and tile output
  logic [ACC_W-1:0]  acc_q [OUT_W];
  logic [ACC_W-1:0]  acc_d [OUT_W];
  logic [ACC_W-1:0]  acc_sum;
  logic              out_valid_q, out_valid_d;
  logic [7:0]        out_data_q, out_data_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;

  logic [7:0]  r8, g8, b8;
  logic [15:0] gray_sum;

  // NOTE: every signal driven here gets a default first, so no path can leave it
  // unassigned and synthesis never infers a latch.
  always_comb begin
    state_d       = state_q;
    flush         = 1'b0;
    frame_error_d = 1'b0;
    frame_ready_d = 1'b0;
    c_done        = b_valid_q && b_flast_q;
    final_in      = pixel_valid && (x_q == X_LAST) && (y_q == Y_LAST);
    unique case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d = ACTIVE;
          flush   = 1'b1;
        end
      end
      ACTIVE: begin
        if (frame_start) begin
          flush         = 1'b1;
          frame_error_d = 1'b1;
        end else if (c_done) begin
          state_d = DONE;
        end else if (frame_end && (y_q != Y_END) && !final_in) begin
          // Final pixel not yet taken: the frame is short, so abandon it
          state_d       = IDLE;
          flush         = 1'b1;
          frame_error_d = 1'b1;
        end
      end
      DONE: begin
        frame_ready_d = 1'b1;
        state_d       = IDLE;
        if (frame_start) begin
          state_d = ACTIVE;
          flush   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    x_base = flush ? '0 : x_q;
    y_base = flush ? '0 : y_q;
    accept = pixel_valid && (state_d == ACTIVE) && (y_base != Y_END);
    x_d    = x_base;
    y_d    = y_base;
    if (accept) begin
      if (x_base == X_LAST) begin
        x_d = '0;
        y_d = y_base + 1'b1;
      end else begin
        x_d = x_base + 1'b1;
      end
    end

    a_valid_d = accept;
    a_data_d  = pixel_data;
    a_col_d   = CW'(x_base >> SH);
    a_last_d  = (&x_base[SH-1:0]) && (&y_base[SH-1:0]);
    a_flast_d = (x_base == X_LAST) && (y_base == Y_LAST);
    a_addr_d  = ADDR_W'(y_base >> SH) * ADDR_W'(OUT_W) + ADDR_W'(x_base >> SH);
  end

  always_comb begin
    r8        = {a_data_q[15:11], a_data_q[15:13]};
    g8        = {a_data_q[10:5],  a_data_q[10:9]};
    b8        = {a_data_q[4:0],   a_data_q[4:2]};
    gray_sum  = 16'd77 * 16'(r8) + 16'd150 * 16'(g8) + 16'd29 * 16'(b8);
    b_valid_d = a_valid_q && !flush;
    b_gray_d  = 8'(gray_sum >> 8);
    b_col_d   = a_col_q;
    b_last_d  = a_last_q;
    b_flast_d = a_flast_q;
    b_addr_d  = a_addr_q;
  end

  always_comb begin
    acc_d       = acc_q;
    acc_sum     = acc_q[b_col_q] + ACC_W'(b_gray_q);
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    if (flush) begin
      acc_d = '{default: '0};
    end else if (b_valid_q) begin
      if (b_last_q) begin
        acc_d[b_col_q] = '0;
        out_valid_d    = 1'b1;
        out_data_d     = acc_sum[ACC_W-1:2*SH];
        out_addr_d     = b_addr_q;
      end else begin
        acc_d[b_col_q] = acc_sum;
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      x_q           <= '0;
      y_q           <= '0;
      frame_error_q <= 1'b0;
      frame_ready_q <= 1'b0;
      a_valid_q     <= 1'b0;
      a_data_q      <= '0;
      a_col_q       <= '0;
      a_last_q      <= 1'b0;
      a_flast_q     <= 1'b0;
      a_addr_q      <= '0;
      b_valid_q     <= 1'b0;
      b_gray_q      <= '0;
      b_col_q       <= '0;
      b_last_q      <= 1'b0;
      b_flast_q     <= 1'b0;
      b_addr_q      <= '0;
      // NOTE: the accumulator array is flop-based and small, so it is reset here;
      // a partial frame must never leak into the next one.
      acc_q         <= '{default: '0};
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_addr_q    <= '0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      frame_error_q <= frame_error_d;
      frame_ready_q <= frame_ready_d;
      a_valid_q     <= a_valid_d;
      a_data_q      <= a_data_d;
      a_col_q       <= a_col_d;
      a_last_q      <= a_last_d;
      a_flast_q     <= a_flast_d;
      a_addr_q      <= a_addr_d;
      b_valid_q     <= b_valid_d;
      b_gray_q      <= b_gray_d;
      b_col_q       <= b_col_d;
      b_last_q      <= b_last_d;
      b_flast_q     <= b_flast_d;
      b_addr_q      <= b_addr_d;
      acc_q         <= acc_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_addr_q    <= out_addr_d;
    end
  end

  // DONE is held for the final beat's cycle so busy drops together with frame_ready
  assign busy        = (state_q != IDLE);
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_addr    = out_addr_q;
  assign frame_ready = frame_ready_q;
  assign frame_error = frame_error_q;

endmodule
